// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants: tag field layout, rw/device encodings and the responder state type.
package sysbus_pkg;

  localparam logic SYSBUS_READ  = 1'b0;
  localparam logic SYSBUS_WRITE = 1'b1;

  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  localparam int unsigned TAG_RW_BIT  = 12;
  localparam int unsigned TAG_DEV_MSB = 11;
  localparam int unsigned TAG_DEV_LSB = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StResp,
    StWdata
  } resp_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Word store with one bus write port, one backdoor write port and one combinational read port.
module sysbus_mem_array #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4096,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             init_we_i,
  input  logic [AddrW-1:0] init_addr_i,
  input  logic [Width-1:0] init_data_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic             init_blocked;

  // A bus write to the same word on the same edge takes priority over the backdoor.
  assign init_blocked = we_i && (waddr_i == init_addr_i);

  always_ff @(posedge clk_i) begin
    if (init_we_i && !init_blocked) begin
      mem_q[init_addr_i] <= init_data_i;
    end
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: accepts line reads/writes, waits a fixed latency and
// returns read lines as respack-paced beat bursts.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned MEM_WORDS      = 4096,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  input  logic                      init_we,
  input  logic [AW-1:0]             init_addr,
  input  logic [BUS_DATA_WIDTH-1:0] init_data
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_e               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [AW-1:0]             base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

  logic                      is_mem;
  logic                      mem_we;
  logic [AW-1:0]             word_addr;
  logic [AW-1:0]             raddr;
  logic [BUS_DATA_WIDTH-1:0] rdata;

  assign is_mem    = (tag_q[TAG_DEV_MSB:TAG_DEV_LSB] == SYSBUS_MEMORY);
  assign word_addr = base_q + AW'(beat_q);

  sysbus_mem_array #(
    .Width (BUS_DATA_WIDTH),
    .Depth (MEM_WORDS)
  ) u_mem_array (
    .clk_i       (clk),
    .we_i        (mem_we),
    .waddr_i     (word_addr),
    .wdata_i     (bus_req),
    .init_we_i   (init_we),
    .init_addr_i (init_addr),
    .init_data_i (init_data),
    .raddr_i     (raddr),
    .rdata_o     (rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    tag_d     = tag_q;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;
    raddr     = word_addr;

    unique case (state_q)
      StIdle: begin
        if (bus_reqcyc) begin
          tag_d    = bus_reqtag;
          // Line index scaled to words; offset bits [5:0] are dropped, upper bits wrap.
          base_d   = AW'(bus_req[BUS_DATA_WIDTH-1:6]) * AW'(BEATS);
          reqack_d = 1'b1;
          beat_d   = '0;
          cnt_d    = '0;
          state_d  = (bus_reqtag[TAG_RW_BIT] == SYSBUS_WRITE) ? StWdata : StDelay;
        end
      end
      StDelay: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          cnt_d     = '0;
          state_d   = StResp;
          respcyc_d = 1'b1;
          resp_d    = is_mem ? rdata : '0;
          resptag_d = tag_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        if (bus_respack) begin
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d    = '0;
            respcyc_d = 1'b0;
            resp_d    = '0;
            state_d   = StIdle;
          end else begin
            beat_d = beat_q + BW'(1);
            raddr  = word_addr + AW'(1);
            resp_d = is_mem ? rdata : '0;
          end
        end
      end
      StWdata: begin
        if (bus_reqcyc) begin
          mem_we = is_mem;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      tag_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Header ack is registered; write-beat acks follow reqcyc directly.
  assign bus_reqack  = reqack_q | ((state_q == StWdata) & bus_reqcyc);
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Memory-side responder for the Sysbus request/response protocol driven by the core's fetch and data paths. It accepts read and write line requests, applies a fixed access latency, and returns read lines as a burst of beats, each beat released by the initiator's respack. It backs a word-addressed internal store that the bench preloads through a backdoor port. It is the simulation memory model that sits opposite top on the bus.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp and of one memory word
BUS_TAG_WIDTH, 13, tag width; layout {rw[12], device[11:8], id[7:0]}
BEATS, 8, beats per line (line = BEATS*8 bytes = 64 B)
LATENCY, 4, cycles from request reqack to the first response beat (>=1)
MEM_WORDS, 4096, store depth in 64-bit words (power of two, multiple of BEATS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bus_reqcyc  in  1  request valid / write-beat valid
bus_req  in  BUS_DATA_WIDTH  byte address (header cycle) or write data (beat cycles)
bus_reqtag  in  BUS_TAG_WIDTH  request tag
bus_reqack  out  1  request or write beat accepted
bus_respcyc  out  1  response beat valid
bus_resp  out  BUS_DATA_WIDTH  response data
bus_resptag  out  BUS_TAG_WIDTH  echo of the accepted request tag
bus_respack  in  1  initiator consumed the current beat
init_we  in  1  backdoor write enable
init_addr  in  $clog2(MEM_WORDS)  backdoor word index
init_data  in  BUS_DATA_WIDTH  backdoor write data

Behaviour:
- Reset (async): state IDLE; reqack=0, respcyc=0, resp=0, resptag=0; beat and delay counters 0. Store contents are not reset. Reset asserted mid-burst aborts the burst; no further beats are issued.
- Line address = bus_req[63:6]; bits [5:0] are ignored, so beats always run from word 0 of the line. Word index = line*BEATS + beat, taken modulo MEM_WORDS (wrap-around).
- IDLE: bus_reqcyc sampled high at edge k -> latch address and tag; bus_reqack=1 (registered) for exactly cycle k+1. Next state is WDATA if rw=SYSBUS_WRITE, else DELAY.
- DELAY: counter runs LATENCY-1 cycles. The first respcyc cycle is reqack cycle + LATENCY.
- RESP: respcyc=1, resp=store[line word + beat], resptag=latched tag. respcyc stays high throughout the burst. The beat advances on an edge with respack=1; with respack=0 the beat holds (stall). The edge that acknowledges beat BEATS-1 clears respcyc -> IDLE. reqcyc is ignored outside IDLE/WDATA.
- WDATA: bus_reqack = bus_reqcyc (combinational). Each edge with reqcyc=1 stores bus_req to the next word. After BEATS beats -> IDLE. No response phase for writes.
- If device != SYSBUS_MEMORY: the request is still acknowledged. A read returns all-zero beats with normal timing. Write beats are accepted and discarded.
- Backdoor: init_we writes init_data on any edge. If it collides with a bus write to the same word on the same edge, the bus write wins.
- A read and a bus write never overlap; one transaction is outstanding at a time.

Decomposition:
- Shared package sysbus_pkg holds the SYSBUS_READ/SYSBUS_WRITE and SYSBUS_MEMORY constants, the tag field positions, and the responder state enum {IDLE, DELAY, RESP, WDATA}.
- One sub-module, sysbus_mem_array: single-write-port, single-read-port array with a backdoor priority mux.

Test Plan:
- Preload words 0x40..0x47 = 0x1000+i; read addr 0x200, tag id 0x05, respack held high -> reqack 1 cycle; 4 cycles later 8 consecutive beats 0x1000..0x1007 with resptag id 0x05; respcyc low afterwards.
- Same read with addr 0x23C -> identical beats (offset ignored).
- Read with respack toggling 1,0,0,1,... -> each beat held during stall cycles; no beat skipped or repeated; exactly 8 acknowledged beats.
- Write to 0x400 with beats 0xA0..0xA7, then read 0x400 -> reqack high on each beat cycle; readback 0xA0..0xA7.
- Read addr = MEM_WORDS*8 + 0x40 -> data from words 8..15 (wrap); device field 0x0 read -> 8 zero beats.
- Assert reset during beat 3 of a read -> respcyc=0 immediately; next read after release completes normally with correct data.
